// File: rtl/key_step_pulser.sv
// Debounced single-step pulser for an active-low push-button: 2-FF sync -> debounce FSM -> one-cycle pulse.
// Define AUTO_REPEAT_EN to emit repeat pulses while the key stays held (REPEAT_DELAY, then every REPEAT_PERIOD).
module key_step_pulser #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        KeyN,
    output logic        StepPulse,
    output logic        Pressed,
    output logic [15:0] PressCount
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_CHK = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_REL_CHK   = 2'd3;

    logic             sync1_q, sync2_q;
    logic             kin;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             pressed_q, pressed_d;
    logic [15:0]      count_q, count_d;
    logic             accept;
    logic             enter_held;
    logic             rep_fire;

    assign kin = ~sync2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_held = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kin) begin
                    state_d = S_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!kin) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_HELD;
                    accept     = 1'b1;
                    enter_held = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!kin) begin
                    state_d = S_REL_CHK;
                    cnt_d   = '0;
                end
            end
            S_REL_CHK: begin
                // A release bounce goes back to HELD silently; only a full stable low run ends the press.
                if (kin) begin
                    state_d    = S_HELD;
                    enter_held = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    logic [RC_W-1:0] rc_q, rc_d;
    logic            first_q, first_d;

    // rc only advances while HELD with the key still down; REL_CHK leaves it frozen.
    always_comb begin
        rc_d     = rc_q;
        first_d  = first_q;
        rep_fire = 1'b0;
        if (enter_held) begin
            rc_d    = '0;
            first_d = 1'b1;
        end else if (state_q == S_HELD && kin) begin
            if (first_q && rc_q == DELAY_LAST) begin
                rep_fire = 1'b1;
                rc_d     = '0;
                first_d  = 1'b0;
            end else if (!first_q && rc_q == PERIOD_LAST) begin
                rep_fire = 1'b1;
                rc_d     = '0;
            end else begin
                rc_d = rc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rc_q    <= '0;
            first_q <= 1'b1;
        end else begin
            rc_q    <= rc_d;
            first_q <= first_d;
        end
    end
`else
    logic [1:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign rep_fire          = 1'b0;
`endif

    always_comb begin
        step_d    = accept | rep_fire;
        count_d   = step_d ? count_q + 16'd1 : count_q;
        pressed_d = (state_d == S_HELD) || (state_d == S_REL_CHK);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            sync1_q   <= KeyN;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            pressed_q <= pressed_d;
            count_q   <= count_d;
        end
    end

    assign StepPulse  = step_q;
    assign Pressed    = pressed_q;
    assign PressCount = count_q;

endmodule

// File: tb/tb_key_step_pulser.sv
// Scoreboard bench for key_step_pulser: expected pulses (cycle, count) are queued as the key is driven.
module tb_key_step_pulser;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        KeyN  = 1'b1;
    logic        StepPulse;
    logic        Pressed;
    logic [15:0] PressCount;

    key_step_pulser #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .KeyN      (KeyN),
        .StepPulse (StepPulse),
        .Pressed   (Pressed),
        .PressCount(PressCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count = 16'd0;
    logic        prev_step = 1'b0;
    int          n_chk     = 0;
    int          n_pass    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic push_pulse(input int at);
        exp_t x;
        exp_count = exp_count + 16'd1;
        x.cyc     = at;
        x.cnt     = exp_count;
        sb.push_back(x);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge Clk) begin : mon
        exp_t x;
        if (StepPulse) begin
            check("no_back_to_back", 32'(prev_step), 32'd0);
            if (sb.size() == 0) begin
                x.cyc = -1;
                x.cnt = exp_count;
            end else begin
                x = sb.pop_front();
            end
            check("pulse_cycle", cyc, x.cyc);
            check("pulse_count", 32'(PressCount), 32'(x.cnt));
        end
        prev_step = StepPulse;
    end

    task automatic drive(input logic v, input int n, input logic chk_p, input logic exp_p);
        KeyN = v;
        repeat (n) begin
            @(negedge Clk);
            if (chk_p) check("pressed_level", 32'(Pressed), 32'(exp_p));
        end
    endtask

    task automatic press_release(input int low);
        int  e;
        logic rej;
        e   = cyc + 1;
        rej = (low <= DB);
        if (!rej) push_pulse(e + DB + 2);
        drive(1'b0, low, rej, 1'b0);
        if (low >= DB + 4) begin
            check("held_pressed", 32'(Pressed), 32'd1);
            check("held_count", 32'(PressCount), 32'(exp_count));
        end
        drive(1'b1, DB + 4, rej, 1'b0);
        check("released_pressed", 32'(Pressed), 32'd0);
        check("count_after", 32'(PressCount), 32'(exp_count));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int e;
        int a;
        int t;

        repeat (2) begin
            @(negedge Clk);
            check("reset_step", 32'(StepPulse), 32'd0);
            check("reset_pressed", 32'(Pressed), 32'd0);
            check("reset_count", 32'(PressCount), 32'd0);
        end
        Reset = 1'b0;
        while (cyc < 9) @(negedge Clk);

        // Low sampled from edge 10: pulse expected after edge 16.
        press_release(9);
        press_release(3);
        press_release(4);
        press_release(5);

        // Release bounce while HELD: Pressed must stay high, no extra pulse.
        e = cyc + 1;
        push_pulse(e + DB + 2);
        drive(1'b0, 8, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b1, 1'b1);
        drive(1'b0, 6, 1'b1, 1'b1);
        drive(1'b1, DB + 4, 1'b0, 1'b0);
        check("bounce_released", 32'(Pressed), 32'd0);
        check("bounce_count", 32'(PressCount), 32'(exp_count));

        // Counter wrap: preload to 0xFFFF, next accepted press gives 0x0000.
        force dut.count_q = 16'hFFFF;
        @(negedge Clk);
        @(negedge Clk);
        release dut.count_q;
        exp_count = 16'hFFFF;
        @(negedge Clk);
        check("count_preload", 32'(PressCount), 32'h0000FFFF);
        press_release(6);
        check("count_wrapped", 32'(PressCount), 32'd0);
        press_release(6);

        // Long hold: 30 cycles past acceptance.
        e = cyc + 1;
        a = e + DB + 2;
        push_pulse(a);
`ifdef AUTO_REPEAT_EN
        t = a + RD;
        while (t <= a + 31) begin
            push_pulse(t);
            t = t + RP;
        end
`else
        t = 0;
`endif
        drive(1'b0, DB + 2 + 30, 1'b0, 1'b0);
        drive(1'b1, DB + 4, 1'b0, 1'b0);
        check("hold_released", 32'(Pressed), 32'd0);
        check("hold_count", 32'(PressCount), 32'(exp_count));

        // Reset mid-hold, key kept down through and after reset.
        e = cyc + 1;
        push_pulse(e + DB + 2);
        drive(1'b0, 9, 1'b0, 1'b0);
        check("pre_reset_pressed", 32'(Pressed), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_step", 32'(StepPulse), 32'd0);
        check("midrst_pressed", 32'(Pressed), 32'd0);
        check("midrst_count", 32'(PressCount), 32'd0);
        Reset     = 1'b0;
        exp_count = 16'd0;
        push_pulse(cyc + 1 + DB + 2);
        drive(1'b0, 9, 1'b0, 1'b0);
        drive(1'b1, DB + 4, 1'b0, 1'b0);
        check("repress_released", 32'(Pressed), 32'd0);
        check("repress_count", 32'(PressCount), 32'd1);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
